data_mem_ctrl: RTL

//  Data-memory stage directly downstream of the MemTR write-data mux.

---
 rtl/data_mem_ctrl_pkg.sv | 15 +
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/data_mem_ctrl_dm_array.sv | 25 ++
 rtl/data_mem_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and default parameters for the data-memory stage that sits
// after the MemTR write-data mux.
package data_mem_ctrl_pkg;

    localparam int E_DEFAULT    = 32;
    localparam int AW_DEFAULT   = 6;
    localparam int WAIT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MemTR mux stage (master) and the
// data-memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int E = 32
);
    logic         req;
    logic         MemTR;
    logic [E-1:0] addr;
    logic [E-1:0] DW;
    logic [E-1:0] DR;
    logic         ack;
    logic         busy;
    logic         err;

    modport master (
        output req, MemTR, addr, DW,
        input  DR, ack, busy, err
    );

    modport slave (
        input  req, MemTR, addr, DW,
        output DR, ack, busy, err
    );
endinterface

// File: rtl/data_mem_ctrl_dm_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset
// so contents survive a controller reset.
module dm_array #(
    parameter int E  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [E-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [E-1:0]  rdata
);

    logic [E-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: accepts one request in IDLE, spends
// WAIT cycles in ACCESS, then pulses ack (with err for out-of-range) in DONE.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int E    = E_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int WAIT = WAIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WAIT) + 1;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;

    logic            write_q;
    logic            oor_q;
    logic [AW-1:0]   addr_q;
    logic [E-1:0]    wdata_q;
    logic [E-1:0]    dr_q;

    logic            accept;
    logic            complete;
    logic            we;
    logic [E-1:0]    rdata;

    assign accept   = (state == IDLE) && bus.req;
    assign complete = (state == ACCESS) && (cnt == '0);
    // A write only lands on the ACCESS->DONE edge, so a reset before then drops it.
    assign we       = complete && write_q && !oor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_next = ACCESS;
                    cnt_next   = CW'(WAIT - 1);
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= bus.MemTR;
            oor_q   <= |bus.addr[E-1:AW];
            addr_q  <= bus.addr[AW-1:0];
            wdata_q <= bus.DW;
        end
    end

    // DR changes only when a read completes; writes and idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_q <= '0;
        end else if (complete && !write_q) begin
            dr_q <= oor_q ? '0 : rdata;
        end
    end

    dm_array #(
        .E  (E),
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (rdata)
    );

    assign bus.DR   = dr_q;
    assign bus.ack  = (state == DONE);
    assign bus.busy = (state == ACCESS);
    assign bus.err  = (state == DONE) && oor_q;

endmodule
